mdu_hilo: RTL and testbench
===========================

// Module: mdu_hilo
// PURPOSE
//  Iterative multiply/divide unit with HI/LO registers for the MIPS32 core.
//  It decodes the R-type func field itself and executes MULT/MULTU/DIV/DIVU at 1 bit per cycle.
//  Also executes MFHI/MFLO/MTHI/MTLO.
//  Sits beside the ALU in EX. Raises stall so the pipeline holds while a multiply/divide is in flight.
// PARAMETERS
//  DATA_W     32  operand width; HI and LO are each DATA_W bits wide
//  SIGNED_EN  1   1: MULT and DIV are signed; 0: MULT and DIV execute as MULTU and DIVU
//  CNT_W      $clog2(DATA_W+1)  localparam; width of the iteration counter
// PORTS
//  clk     in   1       clock, rising edge
//  rst_n   in   1       asynchronous active-low reset
//  start   in   1       instruction valid; func, rs_val and rt_val are sampled with it
//  func    in   6       R-type func field
//  rs_val  in   DATA_W  rs operand (dividend / multiplicand / MT source)
//  rt_val  in   DATA_W  rt operand (divisor / multiplier)
//  flush   in   1       synchronous cancel of the operation in flight
//  stall   out  1       comb: start & busy & (func is any of the 8 MDU funcs)
//  busy    out  1       an iteration is in flight
//  done    out  1       one-cycle pulse in the cycle after HI/LO are written by mul/div
//  rd_val  out  DATA_W  comb: hi for MFHI (010000), lo for MFLO (010010), else 0
//  hi, lo  out  DATA_W  architectural HI and LO registers
// BEHAVIOUR
//  Func codes: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
//  Func codes: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
//  start with any other func: ignored; stall stays 0 and no state changes.
//  Reset: state=IDLE; busy, done, hi, lo, counter and all datapath registers are 0.
//   Reset is asynchronous and also aborts any operation in flight.
//  FSM states: IDLE -> RUN -> FIX -> IDLE.
//  IDLE, start & mul/div:
//   - latch |rs| and |rt| (abs value only if the op is signed and SIGNED_EN=1),
//     the result-sign flags and the op class; cnt=0; go to RUN; busy=1.
//  IDLE, start & MTHI/MTLO: hi (or lo) <= rs_val at the next edge; busy stays 0.
//  MF* reads never wait while IDLE; rd_val is valid in the same cycle.
//  RUN: one step per edge; cnt increments; go to FIX when cnt==DATA_W-1.
//   - Multiply: shift-add on a 2*DATA_W product register.
//   - Divide: restoring step on a {rem,quot} register.
//  FIX (1 cycle): apply the sign fix-ups, write hi/lo, go to IDLE; busy=0 and done=1 in the following cycle.
//   - Multiply: {hi,lo} = product, negated when the operand signs differ.
//   - Divide: lo = quotient, negated when the signs differ; hi = remainder, which takes the dividend's sign.
//  Latency: start accepted at edge 0; hi/lo written at edge DATA_W+1; done high during the cycle after that edge.
//  busy covers the cycles after edge 0 up to and including edge DATA_W+1.
//  start while busy: ignored; stall=1 for MDU funcs. The pipeline re-presents the instruction.
//  Cycle in which done=1: busy=0, so a new start is accepted immediately (back-to-back ops).
//  Divide by zero (rt==0): lo = all ones, hi = rs_val unmodified; full latency still applies.
//  Signed DIV of MIN by -1: lo = MIN, hi = 0 (a natural result of unsigned |MIN| arithmetic).
//  flush while RUN/FIX: go to IDLE at the next edge; busy=0; done stays 0; hi/lo unchanged.
//   If flush and start arrive in the same cycle, flush wins.
//  flush while IDLE: no effect, and start that cycle is still honoured.
//  Width rules: all internal arithmetic is DATA_W+1 bits (restoring subtract) or 2*DATA_W bits (product).
//   No truncation until the write in FIX.
// STRUCTURE
//  mdu_pkg holds:
//   - func localparams (FN_MULT..FN_MTLO)
//   - state encoding (ST_IDLE/ST_RUN/ST_FIX)
//   - an is_mdu_func function, shared with the ALU control decoder
//  Sub-module mdu_step: combinational single iteration (mul add-shift / div subtract-restore, selected by op).
//  mdu_hilo holds the FSM, counter, sign logic, HI/LO and the stall/rd_val muxing.
// TESTING (DATA_W=32)
//  MULTU FFFFFFFF x FFFFFFFF -> done exactly 33 edges after the start edge; hi=FFFFFFFE, lo=00000001.
//  MULT -3 x 7 -> hi=FFFFFFFF, lo=FFFFFFEB.
//  DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU 100/7 -> lo=0000000E, hi=00000002.
//  DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
//   DIVU 12345678/0 -> lo=FFFFFFFF, hi=12345678.
//  MFHI presented each cycle during a DIV -> stall=1 while busy; in the done cycle stall=0 and rd_val = new hi.
//   MTLO 0000ABCD while idle -> lo=0000ABCD next edge; busy never rises.
//  flush at RUN cycle 10 -> busy=0 next edge; no done; hi/lo keep their old values.
//   rst_n low mid-RUN -> hi/lo/busy = 0 immediately.

Source files
------------

// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
//   Shared definitions for the multiply/divide unit: R-type func codes handled
//   by the MDU, FSM state encoding, the iteration op select, and the decode
//   helpers (is_mdu_func is also used by the ALU control decoder).
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } mdu_op_e;

    // Any of the eight HI/LO funcs: 0100xx (MF/MT) or 0110xx (MUL/DIV)
    function automatic logic is_mdu_func(input logic [5:0] f);
        return (f[5:2] == 4'b0100) || (f[5:2] == 4'b0110);
    endfunction

    // Only the iterative multiply/divide funcs
    function automatic logic is_muldiv(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// -----------------------------------------------------------------------------
// mdu_step
//   One combinational iteration of the multiply/divide datapath.
//   Ports:
//     op      : OP_MUL (shift-add) or OP_DIV (restoring subtract)
//     acc     : 2*DATA_W accumulator
//                 mul: {partial product hi, multiplier / product lo}
//                 div: {remainder, dividend / quotient}
//     opnd    : multiplicand (mul) or divisor (div)
//     acc_nxt : accumulator after this step
// -----------------------------------------------------------------------------
module mdu_step
    import mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  mdu_op_e               op,
    input  logic [2*DATA_W-1:0]   acc,
    input  logic [DATA_W-1:0]     opnd,
    output logic [2*DATA_W-1:0]   acc_nxt
);

    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_part;
    logic              w_ge;
    logic [DATA_W-1:0] w_rem_nxt;
    logic [2*DATA_W-1:0] w_mul_nxt;
    logic [2*DATA_W-1:0] w_div_nxt;

    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit is set; the carry-out becomes the new MSB after the shift.
    assign w_sum     = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
    assign w_mul_nxt = {w_sum, acc[DATA_W-1:1]};

    // Divide: shift the next dividend bit into the remainder (DATA_W+1 bits
    // so nothing is lost), subtract when it fits, restore otherwise.
    // The remainder stays below the divisor, so the kept value fits DATA_W.
    assign w_part    = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    assign w_ge      = (w_part >= {1'b0, opnd});
    assign w_rem_nxt = DATA_W'(w_ge ? (w_part - {1'b0, opnd}) : w_part);
    assign w_div_nxt = {w_rem_nxt, acc[DATA_W-2:0], w_ge};

    assign acc_nxt = (op == OP_DIV) ? w_div_nxt : w_mul_nxt;

endmodule

// File: rtl/mdu_hilo.sv
// -----------------------------------------------------------------------------
// mdu_hilo
//   Iterative (1 bit/cycle) multiply/divide unit with architectural HI/LO.
//   Decodes MULT/MULTU/DIV/DIVU/MFHI/MTHI/MFLO/MTLO from the R-type func field.
//   Ports:
//     clk, rst_n     : clock (rising edge), async active-low reset
//     start          : instruction valid; func/rs_val/rt_val sampled with it
//     func           : R-type func field
//     rs_val, rt_val : operands (rs = dividend/multiplicand/MT source)
//     flush          : cancel the operation in flight (RUN/FIX only)
//     stall          : start of an MDU func while busy; pipeline must hold
//     busy           : multiply/divide in flight
//     done           : one-cycle pulse after HI/LO written by mul/div
//     rd_val         : HI for MFHI, LO for MFLO, else 0 (combinational)
//     hi, lo         : architectural HI/LO
// -----------------------------------------------------------------------------
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [5:0]        func,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              flush,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_val,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    mdu_state_e          r_state;
    mdu_op_e             r_op;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0] r_acc;
    logic [DATA_W-1:0]   r_opnd;
    logic                r_neg_res;   // operand signs differ
    logic                r_neg_rem;   // dividend negative: remainder takes its sign
    logic                r_div0;
    logic                r_done;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic                w_muldiv;
    logic                w_is_div;
    logic                w_signed;
    logic                w_rs_neg;
    logic                w_rt_neg;
    logic [DATA_W-1:0]   w_rs_abs;
    logic [DATA_W-1:0]   w_rt_abs;
    logic [2*DATA_W-1:0] w_acc_nxt;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quot;
    logic [DATA_W-1:0]   w_rem;
    logic [DATA_W-1:0]   w_fix_lo;
    logic [DATA_W-1:0]   w_fix_hi;

    // ---------------- decode / operand conditioning ----------------
    assign w_muldiv = is_muldiv(func);
    assign w_is_div = (func == FN_DIV) || (func == FN_DIVU);
    assign w_signed = SIGNED_EN && ((func == FN_MULT) || (func == FN_DIV));
    assign w_rs_neg = w_signed & rs_val[DATA_W-1];
    assign w_rt_neg = w_signed & rt_val[DATA_W-1];
    // |MIN| wraps to MIN, which is the correct unsigned magnitude
    assign w_rs_abs = w_rs_neg ? (~rs_val + 1'b1) : rs_val;
    assign w_rt_abs = w_rt_neg ? (~rt_val + 1'b1) : rt_val;

    mdu_step #(.DATA_W(DATA_W)) u_step (
        .op      (r_op),
        .acc     (r_acc),
        .opnd    (r_opnd),
        .acc_nxt (w_acc_nxt)
    );

    // ---------------- sign fix-ups applied in FIX ----------------
    assign w_prod   = r_neg_res ? (~r_acc + 1'b1) : r_acc;
    assign w_quot   = r_acc[DATA_W-1:0];
    assign w_rem    = r_acc[2*DATA_W-1:DATA_W];
    // Divide by zero: quotient forced to all ones; the remainder is already
    // |rs| and regains rs's sign, so hi ends up equal to rs_val.
    assign w_fix_lo = r_div0 ? '1 : (r_neg_res ? (~w_quot + 1'b1) : w_quot);
    assign w_fix_hi = r_neg_rem ? (~w_rem + 1'b1) : w_rem;

    // ---------------- FSM + datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_MUL;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_muldiv) begin
                            r_state   <= ST_RUN;
                            r_cnt     <= '0;
                            r_op      <= w_is_div ? OP_DIV : OP_MUL;
                            r_acc     <= {{DATA_W{1'b0}}, (w_is_div ? w_rs_abs : w_rt_abs)};
                            r_opnd    <= w_is_div ? w_rt_abs : w_rs_abs;
                            r_neg_res <= w_rs_neg ^ w_rt_neg;
                            r_neg_rem <= w_rs_neg;
                            r_div0    <= w_is_div && (rt_val == '0);
                        end else if (func == FN_MTHI) begin
                            r_hi <= rs_val;
                        end else if (func == FN_MTLO) begin
                            r_lo <= rs_val;
                        end
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(DATA_W - 1))
                            r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                    if (!flush) begin
                        r_done <= 1'b1;
                        if (r_op == OP_DIV) begin
                            r_hi <= w_fix_hi;
                            r_lo <= w_fix_lo;
                        end else begin
                            {r_hi, r_lo} <= w_prod;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign busy   = (r_state != ST_IDLE);
    assign done   = r_done;
    assign hi     = r_hi;
    assign lo     = r_lo;
    assign stall  = start & busy & is_mdu_func(func);
    assign rd_val = (func == FN_MFHI) ? r_hi :
                    (func == FN_MFLO) ? r_lo : '0;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: the driver pushes expected {hi,lo} plus the
// acceptance cycle; a monitor pops on every done pulse and checks values and
// latency. Expected results come from plain 64-bit arithmetic.
module tb_mdu_hilo;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [5:0]   func;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         flush;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] rd_val;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    mdu_hilo #(.DATA_W(W), .SIGNED_EN(1'b1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .func   (func),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .rd_val (rd_val),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc0;
    } exp_t;

    exp_t         sbq[$];
    exp_t         mon_e;
    logic [W-1:0] ref_hi = '0;
    logic [W-1:0] ref_lo = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: architectural result of each func, straight from arithmetic
    function automatic void model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] h, output logic [W-1:0] l);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h  = ref_hi;
        l  = ref_lo;
        case (f)
            FN_MULTU: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
            FN_MULT:  begin p = 64'(sa * sb);           h = p[63:32]; l = p[31:0]; end
            FN_DIVU: begin
                if (b == 0) begin h = a; l = '1; end
                else begin l = a / b; h = a % b; end
            end
            FN_DIV: begin
                if (b == 0) begin h = a; l = '1; end
                else begin l = W'(sa / sb); h = W'(sa % sb); end
            end
            FN_MTHI: h = a;
            FN_MTLO: l = a;
            default: ;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding op
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            n_done++;
            chk("done_pending", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) begin
                mon_e = sbq.pop_front();
                chk("hi", hi, mon_e.hi);
                chk("lo", lo, mon_e.lo);
                chk("latency", 64'(cyc - mon_e.cyc0), 64'd33);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    // Called at a negedge; returns at a negedge where the unit is idle
    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 64'(n), 64'd0);
    endtask

    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit track, input bit fl);
        logic [W-1:0] h, l;
        @(negedge clk);
        wait_idle();
        start  = 1'b1;
        func   = f;
        rs_val = a;
        rt_val = b;
        flush  = fl;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        func  = 6'h00;
        if (is_muldiv(f)) begin
            chk("busy_after_start", busy, 1);
            if (track) begin
                model(f, a, b, h, l);
                sbq.push_back('{h, l, cyc});
                ref_hi = h;
                ref_lo = l;
            end
        end else begin
            model(f, a, b, h, l);
            ref_hi = h;
            ref_lo = l;
            chk("mt_hi", hi, ref_hi);
            chk("mt_lo", lo, ref_lo);
            chk("mt_busy", busy, 0);
        end
    endtask

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            3:       return 32'd1;
            4:       return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    logic [5:0] rfn[6] = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO};

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int  d0;
        bit  seen;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; func = 6'h00; rs_val = '0; rt_val = '0;
        #12;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        issue(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
        issue(FN_MULT,  32'hFFFF_FFFD, 32'd7,         1, 0);
        issue(FN_DIV,   32'hFFFF_FFF9, 32'd2,         1, 0);
        issue(FN_DIVU,  32'd100,       32'd7,         1, 0);
        issue(FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
        issue(FN_DIVU,  32'h1234_5678, 32'd0,         1, 0);
        issue(FN_DIV,   32'h8000_0005, 32'd0,         1, 0);
        issue(FN_MULT,  32'h8000_0000, 32'h8000_0000, 1, 0);

        // Ignored func: no stall, rd_val 0, no state change
        @(negedge clk);
        wait_idle();
        start = 1'b1; func = 6'b100000; rs_val = 32'hDEAD_BEEF;
        #1;
        chk("other_stall", stall, 0);
        chk("other_rdval", rd_val, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("other_busy", busy, 0);
        chk("other_hi", hi, ref_hi);

        // MFHI presented every cycle during a DIV
        issue(FN_DIV, 32'd1000, 32'hFFFF_FFF9, 1, 0);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            start = 1'b1; func = FN_MFHI;
            #1;
            if (busy) chk("stall_busy", stall, 1);
            else begin
                chk("stall_done", stall, 0);
                chk("done_with_mf", done, 1);
                chk("mfhi_new", rd_val, ref_hi);
                seen = 1'b1;
            end
        end
        if (!seen) chk("mfhi_timeout", 0, 1);
        func = FN_MFLO;
        #1;
        chk("mflo_idle", rd_val, ref_lo);
        start = 1'b0; func = 6'h00;

        // MT while idle
        issue(FN_MTLO, 32'h0000_ABCD, 32'd0, 1, 0);
        issue(FN_MTHI, 32'h1357_9BDF, 32'd0, 1, 0);

        // Back-to-back ops
        issue(FN_DIVU, 32'hFFFF_FFFF, 32'd3, 1, 0);
        issue(FN_MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1, 0);

        // Flush in RUN: flush beats a simultaneous start
        @(negedge clk);
        wait_idle();
        issue(FN_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0);
        repeat (10) @(negedge clk);
        d0 = n_done;
        flush = 1'b1; start = 1'b1; func = FN_MULTU; rs_val = 32'd3; rt_val = 32'd3;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0; func = 6'h00;
        chk("flush_busy", busy, 0);
        repeat (40) @(negedge clk);
        chk("flush_no_done", 64'(n_done - d0), 64'd0);
        chk("flush_hi", hi, ref_hi);
        chk("flush_lo", lo, ref_lo);

        // Flush while idle: start still honoured
        issue(FN_DIVU, 32'd77, 32'd5, 1, 1);
        issue(FN_MTLO, 32'h0BAD_F00D, 32'd0, 1, 1);

        // Randomized mix
        for (int i = 0; i < 40; i++)
            issue(rfn[$urandom_range(0, 5)], pick_val(), pick_val(), 1, 0);

        // Async reset mid-RUN
        @(negedge clk);
        wait_idle();
        repeat (2) @(negedge clk);
        issue(FN_MULT, 32'hFFFF_1234, 32'h0000_5678, 0, 0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstrun_hi", hi, 0);
        chk("rstrun_lo", lo, 0);
        chk("rstrun_busy", busy, 0);
        ref_hi = '0; ref_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(FN_MULTU, 32'd6, 32'd7, 1, 0);

        @(negedge clk);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
